// File: rtl/read_test_sequencer_pkg.sv
// Shared definitions for the read-throughput sequencer: state encoding,
// host trigger bit positions and the generator word-limit helper.
package read_test_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int TRIG_START_BIT         = 1;
    localparam int TRIG_ABORT_BIT         = 2;
    localparam int TRIG_RESET_PATTERN_BIT = 3;

    // One 64-bit generator word carries two pipe words, so round the length up.
    function automatic logic [31:0] gen_limit_f(input logic [31:0] len);
        return (len + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/read_test_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module read_test_sequencer_sat_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count register: clear beats enable, no wrap past all-ones
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/read_test_sequencer.sv
// Sequences one timed host read run: FIFO/generator clear, optional pre-fill,
// gated generator writes, and a cycle timer that stops on the last pipe read.
module read_test_sequencer
    import read_test_sequencer_pkg::*;
#(
    parameter int FIFO_RST_CYCLES = 8,
    parameter int CNT_W           = 64
) (
    input  logic             okClk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      transfer_len,
    input  logic             prefill_en,
    input  logic             fifo_almost_full,
    input  logic             fifo_empty,
    input  logic             gen_valid,
    input  logic             pipe_read,
    output logic             fifo_rst,
    output logic             gen_rst,
    output logic             gen_enable,
    output logic [CNT_W-1:0] clk_counts,
    output logic [31:0]      words_read,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             underflow_err,
    output logic [2:0]       state_o
);

    localparam logic [31:0] RST_LAST = 32'(FIFO_RST_CYCLES - 1);

    state_t      state_r, next_state_s;
    logic [31:0] len_r, gen_limit_r, gen_count_r, gen_count_next_s;
    logic [31:0] words_read_r, rst_cnt_r;
    logic        prefill_r;
    logic        active_s, start_acc_s, abort_acc_s, count_read_s, count_gen_s;
    logic        rst_last_s, timing_s;
    logic        fifo_rst_r, gen_enable_r, busy_r, done_r, aborted_r, underflow_r;

    // Qualified events; abort masks start and freezes every counter that cycle
    always_comb begin
        active_s         = (state_r == ST_FILL) || (state_r == ST_RUN);
        abort_acc_s      = abort && (active_s || (state_r == ST_CLEAR));
        start_acc_s      = start && !abort && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        count_read_s     = pipe_read && active_s && !abort_acc_s;
        count_gen_s      = gen_valid && active_s && !abort_acc_s;
        timing_s         = (state_r == ST_RUN) && !abort_acc_s;
        rst_last_s       = (rst_cnt_r == RST_LAST);
        gen_count_next_s = start_acc_s ? 32'd0 :
                           (count_gen_s ? gen_count_r + 32'd1 : gen_count_r);
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    next_state_s = (transfer_len != 32'd0) ? ST_CLEAR : ST_DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CLEAR: begin
                if (abort_acc_s) begin
                    next_state_s = ST_IDLE;
                end else if (rst_last_s) begin
                    next_state_s = prefill_r ? ST_FILL : ST_RUN;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
            ST_FILL: begin
                if (abort_acc_s) begin
                    next_state_s = ST_IDLE;
                end else if (fifo_almost_full || (gen_count_r >= gen_limit_r)) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (abort_acc_s) begin
                    next_state_s = ST_IDLE;
                end else if (count_read_s && ((words_read_r + 32'd1) == len_r)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, run parameters, counters and registered status outputs
    always_ff @(posedge okClk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            len_r        <= 32'd0;
            gen_limit_r  <= 32'd0;
            prefill_r    <= 1'b0;
            gen_count_r  <= 32'd0;
            words_read_r <= 32'd0;
            rst_cnt_r    <= 32'd0;
            fifo_rst_r   <= 1'b0;
            gen_enable_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (start_acc_s) begin
                len_r       <= transfer_len;
                gen_limit_r <= gen_limit_f(transfer_len);
                prefill_r   <= prefill_en;
            end
            gen_count_r  <= gen_count_next_s;
            words_read_r <= start_acc_s ? 32'd0 :
                            (count_read_s ? words_read_r + 32'd1 : words_read_r);
            rst_cnt_r    <= ((state_r == ST_CLEAR) && (next_state_s == ST_CLEAR)) ?
                            rst_cnt_r + 32'd1 : 32'd0;
            fifo_rst_r   <= (next_state_s == ST_CLEAR);
            // Generator gating looks at the post-edge state so abort and the limit act at once
            gen_enable_r <= ((next_state_s == ST_FILL) || (next_state_s == ST_RUN)) &&
                            !fifo_almost_full && (gen_count_next_s < gen_limit_r);
            busy_r       <= (next_state_s == ST_CLEAR) || (next_state_s == ST_FILL) ||
                            (next_state_s == ST_RUN);
            done_r       <= (next_state_s == ST_DONE);
            aborted_r    <= abort_acc_s ? 1'b1 : (start_acc_s ? 1'b0 : aborted_r);
            underflow_r  <= (pipe_read && fifo_empty) ? 1'b1 :
                            (start_acc_s ? 1'b0 : underflow_r);
        end
    end

    read_test_sequencer_sat_counter #(
        .W(CNT_W)
    ) u_timer (
        .clk   (okClk),
        .reset (reset),
        .clear (start_acc_s),
        .en    (timing_s),
        .count (clk_counts)
    );

    assign fifo_rst      = fifo_rst_r;
    assign gen_rst       = fifo_rst_r;
    assign gen_enable    = gen_enable_r;
    assign words_read    = words_read_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign aborted       = aborted_r;
    assign underflow_err = underflow_r;
    assign state_o       = state_r;

endmodule
